// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for a single-port SRAM with a 1-cycle synchronous read.
// When idle, functional accesses pass straight through to the memory.
// While a run is in progress the BIST owns the port, and any functional requests are dropped.
// Each read is compared one cycle later. The controller keeps a pass/fail flag,
// the first failing address and the total number of mismatches.
module sram_march_bist_ctrl #(
    parameter int AW = 8,
    parameter int DW = 10
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          bist_start,
    input  logic          func_ena,
    input  logic          func_wea,
    input  logic [AW-1:0] func_addra,
    input  logic [DW-1:0] func_dina,
    output logic [DW-1:0] func_douta,
    output logic          mem_ena,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addra,
    output logic [DW-1:0] mem_dina,
    input  logic [DW-1:0] mem_douta,
    output logic          bist_busy,
    output logic          bist_done,
    output logic          bist_fail,
    output logic [AW-1:0] fail_addr,
    output logic [10:0]   fail_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    localparam logic [AW-1:0] ADDR_MAX = '1;
    localparam logic [DW-1:0] D0 = '0;
    localparam logic [DW-1:0] D1 = '1;

    state_t        state, state_nxt;
    logic [2:0]    elem, elem_nxt;     // march element M0..M5
    logic [AW-1:0] addr, addr_nxt;
    logic          phase, phase_nxt;   // 0: read slot, 1: write slot (two-op elements only)

    logic          is_down, two_op, op_rd, step, last_addr, start_go;
    logic [DW-1:0] rd_exp, wr_dat;

    logic          cmp_vld;
    logic [DW-1:0] cmp_exp;
    logic [AW-1:0] cmp_addr;

    assign bist_busy  = (state == S_RUN) || (state == S_FLUSH);
    assign bist_done  = (state == S_DONE);
    assign func_douta = mem_douta;
    assign start_go   = bist_start && ((state == S_IDLE) || (state == S_DONE));

    // Decode the current march element into its direction, operation and data pattern.
    always_comb begin
        is_down   = (elem == 3'd3) || (elem == 3'd4);
        two_op    = (elem >= 3'd1) && (elem <= 3'd4);
        op_rd     = (elem == 3'd5) || (two_op && !phase);
        step      = !two_op || phase;
        last_addr = is_down ? (addr == '0) : (addr == ADDR_MAX);
        rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? D1 : D0;
        wr_dat    = ((elem == 3'd1) || (elem == 3'd3)) ? D1 : D0;
    end

    // State register, together with the element, address and phase counters.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            elem  <= '0;
            addr  <= '0;
            phase <= 1'b0;
        end else begin
            state <= state_nxt;
            elem  <= elem_nxt;
            addr  <= addr_nxt;
            phase <= phase_nxt;
        end
    end

    // Next-state logic: walk the element ops and addresses, then step to the next element.
    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = addr;
        phase_nxt = phase;
        case (state)
            S_IDLE, S_DONE: begin
                if (bist_start) begin
                    state_nxt = S_RUN;
                    elem_nxt  = '0;
                    addr_nxt  = '0;
                    phase_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (step) begin
                    phase_nxt = 1'b0;
                    if (last_addr) begin
                        if (elem == 3'd5) begin
                            state_nxt = S_FLUSH;
                            elem_nxt  = '0;
                            addr_nxt  = '0;
                        end else begin
                            elem_nxt = elem + 3'd1;
                            // Elements M3 and M4 run downwards, so they start at the top address.
                            addr_nxt = ((elem == 3'd2) || (elem == 3'd3)) ? ADDR_MAX : '0;
                        end
                    end else begin
                        addr_nxt = is_down ? addr - 1'b1 : addr + 1'b1;
                    end
                end else begin
                    phase_nxt = 1'b1;
                end
            end
            S_FLUSH: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Port mux: functional requests pass through when idle; during a run the BIST drives the port.
    always_comb begin
        mem_ena   = func_ena;
        mem_wea   = func_wea;
        mem_addra = func_addra;
        mem_dina  = func_dina;
        if (bist_busy) begin
            mem_ena   = (state == S_RUN);
            mem_wea   = (state == S_RUN) && !op_rd;
            mem_addra = addr;
            mem_dina  = op_rd ? D0 : wr_dat;
        end
    end

    // Register each BIST read, then check it against the returned data on the next cycle.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            cmp_vld    <= 1'b0;
            cmp_exp    <= '0;
            cmp_addr   <= '0;
            bist_fail  <= 1'b0;
            fail_addr  <= '0;
            fail_count <= '0;
        end else begin
            cmp_vld  <= (state == S_RUN) && op_rd;
            cmp_exp  <= rd_exp;
            cmp_addr <= addr;
            if (start_go) begin
                bist_fail  <= 1'b0;
                fail_addr  <= '0;
                fail_count <= '0;
            end else if (cmp_vld && (mem_douta != cmp_exp)) begin
                bist_fail  <= 1'b1;
                fail_count <= fail_count + 11'd1;
                if (!bist_fail)
                    fail_addr <= cmp_addr;
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Directed bench for sram_march_bist_ctrl.
// The SRAM model supports stuck-at fault injection at a chosen address and bit.
module tb_sram_march_bist_ctrl;

    logic        clka = 1'b0;
    logic        rst;
    logic        bist_start;
    logic        func_ena, func_wea;
    logic [7:0]  func_addra;
    logic [9:0]  func_dina, func_douta;
    logic        mem_ena, mem_wea;
    logic [7:0]  mem_addra;
    logic [9:0]  mem_dina, mem_douta;
    logic        bist_busy, bist_done, bist_fail;
    logic [7:0]  fail_addr;
    logic [10:0] fail_count;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    // Fault injection controls for the SRAM model.
    logic       sa1_en = 1'b0, sa0_en = 1'b0;
    logic [7:0] sa1_addr = '0, sa0_addr = '0;
    int         sa1_bit = 0, sa0_bit = 0;

    logic [9:0] ram [256];

    sram_march_bist_ctrl #(.AW(8), .DW(10)) dut (
        .clka(clka), .rst(rst), .bist_start(bist_start),
        .func_ena(func_ena), .func_wea(func_wea), .func_addra(func_addra),
        .func_dina(func_dina), .func_douta(func_douta),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta),
        .bist_busy(bist_busy), .bist_done(bist_done), .bist_fail(bist_fail),
        .fail_addr(fail_addr), .fail_count(fail_count)
    );

    always #5 clka = ~clka;

    function automatic logic [9:0] rd_fault(input logic [7:0] a);
        logic [9:0] v;
        v = ram[a];
        if (sa1_en && a == sa1_addr) v[sa1_bit] = 1'b1;
        if (sa0_en && a == sa0_addr) v[sa0_bit] = 1'b0;
        return v;
    endfunction

    // SRAM model: synchronous read with 1-cycle latency.
    always @(posedge clka) begin
        if (mem_ena) begin
            if (mem_wea) ram[mem_addra] <= mem_dina;
            else         mem_douta      <= rd_fault(mem_addra);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue a start pulse, then count the cycles for which busy is high.
    // The task is entered at a negedge. If rst_at is nonzero, reset is asserted at that cycle.
    task automatic run_bist(input bit mid_start, input int rst_at, output int cnt);
        bist_start = 1'b1;
        @(negedge clka);
        bist_start = 1'b0;
        cnt = 0;
        while (bist_busy && cnt < 5000) begin
            cnt++;
            if (cnt == 1) begin
                chk("start_done", bist_done, 0);
                chk("start_fail", bist_fail, 0);
                chk("start_addr", fail_addr, 0);
                chk("start_cnt", fail_count, 0);
            end
            if (cnt == 50) begin
                func_ena = 1'b1; func_wea = 1'b1; func_addra = 8'h2A; func_dina = 10'h155;
                #1;
                chk("blk_addr", mem_addra, 8'd49);
                chk("blk_dina", mem_dina, 10'h000);
            end
            if (cnt == 51) begin
                func_ena = 1'b0; func_wea = 1'b0;
            end
            if (mid_start && cnt == 100) bist_start = 1'b1;
            if (cnt == 101) bist_start = 1'b0;
            if (rst_at != 0 && cnt == rst_at) begin
                chk("pre_rst_cnt", fail_count, 1);
                rst = 1'b1;
                #1;
                chk("rst_busy", bist_busy, 0);
                chk("rst_done", bist_done, 0);
                chk("rst_fail", bist_fail, 0);
                chk("rst_faddr", fail_addr, 0);
                chk("rst_fcnt", fail_count, 0);
                chk("rst_mux_addr", mem_addra, 8'h2A);
                break;
            end
            @(negedge clka);
        end
        if (cnt >= 5000) chk("timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 10'(i * 7);
        mem_douta = '0;
        rst = 1'b1; bist_start = 1'b0;
        func_ena = 1'b0; func_wea = 1'b0; func_addra = '0; func_dina = '0;
        @(negedge clka);
        chk("rst0_busy", bist_busy, 0);
        chk("rst0_done", bist_done, 0);
        chk("rst0_fail", bist_fail, 0);
        chk("rst0_cnt", fail_count, 0);
        @(negedge clka);
        rst = 1'b0;

        // Functional passthrough: a write followed by a read-back.
        func_ena = 1'b1; func_wea = 1'b1; func_addra = 8'h2A; func_dina = 10'h155;
        #1;
        chk("pt_ena", mem_ena, 1);
        chk("pt_wea", mem_wea, 1);
        chk("pt_addr", mem_addra, 8'h2A);
        chk("pt_dina", mem_dina, 10'h155);
        @(negedge clka);
        func_wea = 1'b0; func_dina = 10'h0;
        #1;
        chk("pt_rd_wea", mem_wea, 0);
        @(negedge clka);
        func_ena = 1'b0;
        chk("pt_douta", func_douta, 10'h155);

        // Clean run.
        @(negedge clka);
        run_bist(1'b0, 0, cyc);
        chk("clean_len", cyc, 2561);
        chk("clean_done", bist_done, 1);
        chk("clean_busy", bist_busy, 0);
        chk("clean_fail", bist_fail, 0);
        chk("clean_cnt", fail_count, 0);

        // Bit 3 stuck at 1 at address 0x40.
        sa1_en = 1'b1; sa1_addr = 8'h40; sa1_bit = 3;
        run_bist(1'b0, 0, cyc);
        chk("sa1_len", cyc, 2561);
        chk("sa1_fail", bist_fail, 1);
        chk("sa1_addr", fail_addr, 8'h40);
        chk("sa1_cnt", fail_count, 3);

        // Two faults: bit 9 stuck at 0 at 0xFF and bit 0 stuck at 1 at 0x01.
        sa1_addr = 8'h01; sa1_bit = 0;
        sa0_en = 1'b1; sa0_addr = 8'hFF; sa0_bit = 9;
        run_bist(1'b0, 0, cyc);
        chk("multi_fail", bist_fail, 1);
        chk("multi_addr", fail_addr, 8'h01);
        chk("multi_cnt", fail_count, 5);

        // Restart from DONE with no faults, plus a start pulse during the run that must be ignored.
        sa1_en = 1'b0; sa0_en = 1'b0;
        run_bist(1'b1, 0, cyc);
        chk("rs_len", cyc, 2561);
        chk("rs_done", bist_done, 1);
        chk("rs_fail", bist_fail, 0);
        chk("rs_addr", fail_addr, 0);
        chk("rs_cnt", fail_count, 0);

        // Reset in the middle of a run, then a clean full run.
        sa1_en = 1'b1; sa1_addr = 8'h40; sa1_bit = 3;
        run_bist(1'b0, 1000, cyc);
        @(negedge clka);
        rst = 1'b0;
        sa1_en = 1'b0;
        @(negedge clka);
        run_bist(1'b0, 0, cyc);
        chk("pr_len", cyc, 2561);
        chk("pr_done", bist_done, 1);
        chk("pr_fail", bist_fail, 0);
        chk("pr_cnt", fail_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
